// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: funct3 sizes, FSM states,
// byte strobes and the bus command payload.
package mem_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [STRB_W-1:0] STRB_NONE = 4'b0000;
  localparam logic [STRB_W-1:0] STRB_BYTE = 4'b0001;
  localparam logic [STRB_W-1:0] STRB_HALF = 4'b0011;
  localparam logic [STRB_W-1:0] STRB_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mau_state_e;

  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_cmd_t;

  // Legal size/direction combination with natural alignment
  function automatic logic access_legal(input logic [2:0] f3,
                                        input logic [1:0] a_lo,
                                        input logic       is_write);
    case (f3)
      F3_B:    return 1'b1;
      F3_H:    return ~a_lo[0];
      F3_W:    return (a_lo == 2'b00);
      F3_BU:   return ~is_write;
      F3_HU:   return ~is_write & ~a_lo[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store replication/strobes and load
// extraction with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   load_word,
  output logic [XLEN-1:0]   lane_wdata,
  output logic [STRB_W-1:0] lane_wstrb,
  output logic [XLEN-1:0]   load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = load_word[{addr_lo, 3'b000} +: 8];
    ld_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
  end

  // Store lanes: narrow data is replicated, the strobe picks the live lane
  always_comb begin
    lane_wdata = store_data;
    lane_wstrb = STRB_NONE;
    case (funct3)
      F3_B: begin
        lane_wdata = {4{store_data[7:0]}};
        lane_wstrb = STRB_BYTE << addr_lo;
      end
      F3_H: begin
        lane_wdata = {2{store_data[15:0]}};
        lane_wstrb = addr_lo[1] ? STRB_W'(STRB_HALF << 2) : STRB_HALF;
      end
      F3_W: begin
        lane_wdata = store_data;
        lane_wstrb = STRB_WORD;
      end
      default: begin
        lane_wdata = store_data;
        lane_wstrb = STRB_NONE;
      end
    endcase
  end

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_W:    load_data = load_word;
      F3_BU:   load_data = {24'd0, ld_byte};
      F3_HU:   load_data = {16'd0, ld_half};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Multicycle load/store port: turns held mem_read/mem_write levels into one
// valid/ready bus transfer and returns a single-cycle mem_response.
module memory_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [XLEN-1:0]     address,
  input  logic [XLEN-1:0]     write_data,
  input  logic [2:0]          funct3,
  output logic [XLEN-1:0]     read_data,
  output logic                mem_response,
  output logic                misaligned,
  output logic                bus_error,
  output logic                bus_req,
  output logic                bus_we,
  output logic [XLEN-1:0]     bus_addr,
  output logic [XLEN-1:0]     bus_wdata,
  output logic [STRB_W-1:0]   bus_wstrb,
  input  logic                bus_ready,
  input  logic [XLEN-1:0]     bus_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mau_state_e        state_q, state_d;
  bus_cmd_t          cmd_q, cmd_d;
  logic              req_q, req_d;
  logic              resp_q, resp_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        alo_q, alo_d;
  logic              wr_q, wr_d;

  logic              in_idle;
  logic [2:0]        la_f3;
  logic [1:0]        la_alo;
  logic [XLEN-1:0]   lane_wdata;
  logic [STRB_W-1:0] lane_wstrb;
  logic [XLEN-1:0]   load_data;

  // In IDLE the aligner steers incoming store data; afterwards it extracts
  // the load using the latched size and offset.
  always_comb begin
    in_idle = (state_q == ST_IDLE);
    la_f3   = in_idle ? funct3 : f3_q;
    la_alo  = in_idle ? address[1:0] : alo_q;
  end

  mem_lane_align u_lane_align (
    .funct3     (la_f3),
    .addr_lo    (la_alo),
    .store_data (write_data),
    .load_word  (bus_rdata),
    .lane_wdata (lane_wdata),
    .lane_wstrb (lane_wstrb),
    .load_data  (load_data)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    req_d   = req_q;
    resp_d  = 1'b0;
    mis_d   = mis_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    alo_d   = alo_q;
    wr_d    = wr_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          f3_d  = funct3;
          alo_d = address[1:0];
          wr_d  = mem_write;
          cnt_d = '0;
          mis_d = 1'b0;
          err_d = 1'b0;
          if (access_legal(funct3, address[1:0], mem_write)) begin
            cmd_d.we    = mem_write;
            cmd_d.addr  = {address[31:2], 2'b00};
            cmd_d.wdata = mem_write ? lane_wdata : cmd_q.wdata;
            cmd_d.wstrb = mem_write ? lane_wstrb : STRB_NONE;
            req_d       = 1'b1;
            state_d     = ST_REQ;
          end else begin
            mis_d   = 1'b1;
            resp_d  = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_REQ: begin
        if (bus_ready) begin
          req_d    = 1'b0;
          cmd_d.we = 1'b0;
          if (!wr_q) rdata_d = load_data;
          resp_d   = 1'b1;
          state_d  = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          // Give up on the bus; a failed read reports zero data
          req_d    = 1'b0;
          cmd_d.we = 1'b0;
          err_d    = 1'b1;
          if (!wr_q) rdata_d = '0;
          resp_d   = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        mis_d   = 1'b0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      req_q   <= 1'b0;
      resp_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      f3_q    <= '0;
      alo_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      alo_q   <= alo_d;
      wr_q    <= wr_d;
    end
  end

  assign read_data    = rdata_q;
  assign mem_response = resp_q;
  assign misaligned   = mis_q;
  assign bus_error    = err_q;
  assign bus_req      = req_q;
  assign bus_we       = cmd_q.we;
  assign bus_addr     = cmd_q.addr;
  assign bus_wdata    = cmd_q.wdata;
  assign bus_wstrb    = cmd_q.wstrb;

endmodule

// File: tb/tb_memory_access_unit.sv
// Table-driven bench for memory_access_unit with a bus responder model and
// an expected-response queue, plus reset corner sequences.
module tb_memory_access_unit;

  localparam int unsigned TMO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] read_data;
  logic        mem_response;
  logic        misaligned;
  logic        bus_error;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  always #5 clock = ~clock;

  memory_access_unit #(.TIMEOUT(TMO)) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .address      (address),
    .write_data   (write_data),
    .funct3       (funct3),
    .read_data    (read_data),
    .mem_response (mem_response),
    .misaligned   (misaligned),
    .bus_error    (bus_error),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_ready    (bus_ready),
    .bus_rdata    (bus_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        exp_err;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    int          exp_lat;
    int          exp_reqs;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int waits,
                              input logic [31:0] exp_rd, input logic mis, input logic err,
                              input logic we, input logic [31:0] ewd, input logic [3:0] estrb,
                              input int lat, input int reqs);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.waits = waits; v.exp_rd = exp_rd; v.exp_mis = mis; v.exp_err = err; v.exp_we = we;
    v.exp_wdata = ewd; v.exp_strb = estrb; v.exp_lat = lat; v.exp_reqs = reqs;
    return v;
  endfunction

  // Drive one request, act as the bus slave, and score the response
  task automatic run_vec(input int idx, input vec_t v);
    int   k;
    int   reqs;
    bit   done;
    vec_t e;
    @(negedge clock);
    mem_read   = v.rd;
    mem_write  = v.wr;
    funct3     = v.f3;
    address    = v.addr;
    write_data = v.wdata;
    bus_rdata  = v.rdata;
    bus_ready  = 1'b0;
    exp_q.push_back(v);
    k = 0; reqs = 0; done = 1'b0;
    while (!done && k < 40) begin
      @(negedge clock);
      k++;
      if (mem_response) begin
        e = exp_q.pop_front();
        check($sformatf("v%0d_read_data", idx), read_data, e.exp_rd);
        check($sformatf("v%0d_misaligned", idx), 32'(misaligned), 32'(e.exp_mis));
        check($sformatf("v%0d_bus_error", idx), 32'(bus_error), 32'(e.exp_err));
        check($sformatf("v%0d_latency", idx), 32'(k), 32'(e.exp_lat));
        check($sformatf("v%0d_req_cycles", idx), 32'(reqs), 32'(e.exp_reqs));
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_ready = 1'b0;
        done      = 1'b1;
      end else if (bus_req) begin
        reqs++;
        if (reqs == 1) begin
          check($sformatf("v%0d_bus_addr", idx), bus_addr, {v.addr[31:2], 2'b00});
          check($sformatf("v%0d_bus_we", idx), 32'(bus_we), 32'(v.exp_we));
          check($sformatf("v%0d_bus_wstrb", idx), 32'(bus_wstrb), 32'(v.exp_strb));
          if (v.exp_we) check($sformatf("v%0d_bus_wdata", idx), bus_wdata, v.exp_wdata);
        end
        bus_ready = (reqs > v.waits);
      end else begin
        bus_ready = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL v%0d_no_response actual=none required=mem_response within 40 cycles", idx);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      bus_ready = 1'b0;
      void'(exp_q.pop_front());
    end
  endtask

  initial begin : main
    int seen;

    //        rd  wr  f3      addr          wdata         rdata         w   exp_rd        mis  err  we   ewd           strb     lat reqs
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0,  32'hDEAD_BEEF, 0, 0, 0, 32'h0,         4'b0000, 2, 1));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_0011, 0,  32'hFFFF_FF80, 0, 0, 0, 32'h0,         4'b0000, 2, 1));
    vecs.push_back(mk(1, 0, 3'b100, 32'h0000_0103, 32'h0,         32'h80FF_0011, 0,  32'h0000_0080, 0, 0, 0, 32'h0,         4'b0000, 2, 1));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0,         0,  32'h0000_0080, 0, 0, 1, 32'hABCD_ABCD, 4'b1100, 2, 1));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0102, 32'h0,         32'h80FF_0011, 2,  32'hFFFF_80FF, 0, 0, 0, 32'h0,         4'b0000, 4, 3));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0000_0200, 32'h0,         32'h1234_F00D, 1,  32'h0000_F00D, 0, 0, 0, 32'h0,         4'b0000, 3, 2));
    vecs.push_back(mk(0, 1, 3'b000, 32'h0000_0201, 32'h1234_56A5, 32'h0,         0,  32'h0000_F00D, 0, 0, 1, 32'hA5A5_A5A5, 4'b0010, 2, 1));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,         1,  32'h0000_F00D, 0, 0, 1, 32'hCAFE_F00D, 4'b1111, 3, 2));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,         0,  32'h0000_F00D, 1, 0, 0, 32'h0,         4'b0000, 1, 0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0103, 32'h0,         32'h0,         0,  32'h0000_F00D, 1, 0, 0, 32'h0,         4'b0000, 1, 0));
    vecs.push_back(mk(0, 1, 3'b100, 32'h0000_0200, 32'h0000_0055, 32'h0,         0,  32'h0000_F00D, 1, 0, 0, 32'h0,         4'b0000, 1, 0));
    vecs.push_back(mk(1, 0, 3'b011, 32'h0000_0200, 32'h0,         32'h0,         0,  32'h0000_F00D, 1, 0, 0, 32'h0,         4'b0000, 1, 0));
    vecs.push_back(mk(1, 0, 3'b110, 32'h0000_0000, 32'h0,         32'h0,         0,  32'h0000_F00D, 1, 0, 0, 32'h0,         4'b0000, 1, 0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h0000_0400, 32'h0102_0304, 32'h0,         0,  32'h0000_F00D, 0, 0, 1, 32'h0102_0304, 4'b1111, 2, 1));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0500, 32'h0,         32'h1122_3344, 0,  32'h1122_3344, 0, 0, 0, 32'h0,         4'b0000, 2, 1));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0504, 32'h0000_0005, 32'h0,         99, 32'h1122_3344, 0, 1, 1, 32'h0000_0005, 4'b1111, 5, 4));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0508, 32'h0,         32'h7777_7777, 99, 32'h0000_0000, 0, 1, 0, 32'h0,         4'b0000, 5, 4));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0102, 32'h0,         32'h80FF_0011, 0,  32'hFFFF_FFFF, 0, 0, 0, 32'h0,         4'b0000, 2, 1));
    vecs.push_back(mk(0, 1, 3'b000, 32'h0000_0003, 32'h0000_00C3, 32'h0,         0,  32'hFFFF_FFFF, 0, 0, 1, 32'hC3C3_C3C3, 4'b1000, 2, 1));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0000_0102, 32'h0,         32'h80FF_0011, 0,  32'h0000_80FF, 0, 0, 0, 32'h0,         4'b0000, 2, 1));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_00FC, 32'h0,         32'h8000_0000, 0,  32'h8000_0000, 0, 0, 0, 32'h0,         4'b0000, 2, 1));

    // Reset values
    repeat (2) @(negedge clock);
    check("reset_bus_req", 32'(bus_req), 32'h0);
    check("reset_bus_we", 32'(bus_we), 32'h0);
    check("reset_bus_addr", bus_addr, 32'h0);
    check("reset_bus_wdata", bus_wdata, 32'h0);
    check("reset_bus_wstrb", 32'(bus_wstrb), 32'h0);
    check("reset_flags", {29'd0, mem_response, misaligned, bus_error}, 32'h0);
    check("reset_read_data", read_data, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset in the middle of a bus wait
    @(negedge clock);
    mem_read = 1'b1; funct3 = 3'b010; address = 32'h0000_0600; bus_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("midreset_req_before", 32'(bus_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("midreset_bus_req", 32'(bus_req), 32'h0);
    check("midreset_bus_addr", bus_addr, 32'h0);
    check("midreset_read_data", read_data, 32'h0);
    check("midreset_response", 32'(mem_response), 32'h0);
    mem_read = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clock);
      if (mem_response || bus_req) seen++;
    end
    check("midreset_abandoned", 32'(seen), 32'h0);
    run_vec(100, mk(1, 0, 3'b010, 32'h0000_0700, 32'h0, 32'hA5A5_5A5A, 0,
                    32'hA5A5_5A5A, 0, 0, 0, 32'h0, 4'b0000, 2, 1));

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
